alu_word_sequencer: RTL and testbench

- Multi-precision operation initiator that drives the n-bit combinational ALU port (ALUA, ALUB, ALUFlagIn, ALUControl) and consumes its outputs (ALUResult, ALUFlags C/Z).
- Accepts one WORDS*n-bit request over a valid/ready handshake and issues it to the ALU one n-bit word per cycle, LSB word first.
- For ADD, the carry is chained through ALUFlagIn. Results are assembled into a WORDS*n-bit response with aggregate carry and zero flags.
- Sits between the datapath request source and the ALU instance.

---
 rtl/alu_word_sequencer.sv | 145 ++++++++++++++
 tb/tb_alu_word_sequencer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// Multi-precision front end for an n-bit combinational ALU: takes one WORDS*n-bit
// request, feeds it to the ALU one word per cycle (LSB first) and assembles the response.
module alu_word_sequencer #(
    parameter int n     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready and rsp_valid are pure decodes of the registered state.
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [3:0]         req_op,
    input  logic [WORDS*n-1:0] req_a,
    input  logic [WORDS*n-1:0] req_b,
    input  logic               req_cin,
    output logic [n-1:0]       ALUA,
    output logic [n-1:0]       ALUB,
    output logic               ALUFlagIn,
    output logic [3:0]         ALUControl,
    input  logic [n-1:0]       ALUResult,
    input  logic               ALUFlagC,
    input  logic               ALUFlagZ,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WORDS*n-1:0] rsp_result,
    output logic               rsp_carry,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic [1:0]         dbg_state
);

    localparam int W  = WORDS * n;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [3:0]    op_q;
    logic          zero_acc;
    logic          supported;
    logic          is_add_q;
    logic [n-1:0]  a_next;
    logic [n-1:0]  b_next;

    always_comb begin
        supported = (req_op == OP_AND) || (req_op == OP_OR) || (req_op == OP_ADD) ||
                    (req_op == OP_NOT) || (req_op == OP_XOR);
        is_add_q  = (op_q == OP_ADD);
        // Wrap on the last word so the select never reaches past the operand.
        nidx      = (idx == LAST) ? '0 : idx + 1'b1;
        a_next    = a_q[int'(nidx)*n +: n];
        b_next    = b_q[int'(nidx)*n +: n];
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            zero_acc   <= 1'b0;
            ALUA       <= '0;
            ALUB       <= '0;
            ALUFlagIn  <= 1'b0;
            ALUControl <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (supported) begin
                            a_q        <= req_a;
                            b_q        <= req_b;
                            op_q       <= req_op;
                            idx        <= '0;
                            zero_acc   <= 1'b1;
                            ALUA       <= req_a[n-1:0];
                            ALUB       <= req_b[n-1:0];
                            ALUControl <= req_op;
                            ALUFlagIn  <= (req_op == OP_ADD) & req_cin;
                            state      <= RUN;
                        end else begin
                            // Unsupported opcode never touches the ALU.
                            rsp_result <= '0;
                            rsp_carry  <= 1'b0;
                            rsp_zero   <= 1'b0;
                            rsp_err    <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                RUN: begin
                    rsp_result[int'(idx)*n +: n] <= ALUResult;
                    zero_acc <= zero_acc & ALUFlagZ;
                    if (idx != LAST) begin
                        idx       <= nidx;
                        ALUA      <= a_next;
                        ALUB      <= b_next;
                        ALUFlagIn <= is_add_q & ALUFlagC;
                    end else begin
                        rsp_carry <= is_add_q & ALUFlagC;
                        rsp_zero  <= zero_acc & ALUFlagZ;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        ALUA       <= '0;
                        ALUB       <= '0;
                        ALUFlagIn  <= 1'b0;
                        ALUControl <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Directed bench for alu_word_sequencer: a bench-side ALU, a whole-word arithmetic model
// checked every cycle, and hand-computed literal expectations per transaction.
module tb_alu_word_sequencer;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [3:0]    req_op = '0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          req_cin = 1'b0;
    logic [N-1:0]  ALUA;
    logic [N-1:0]  ALUB;
    logic          ALUFlagIn;
    logic [3:0]    ALUControl;
    logic [N-1:0]  ALUResult;
    logic          ALUFlagC;
    logic          ALUFlagZ;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_carry;
    logic          rsp_zero;
    logic          rsp_err;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    alu_word_sequencer #(.n(N), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
        .ALUA(ALUA), .ALUB(ALUB), .ALUFlagIn(ALUFlagIn), .ALUControl(ALUControl),
        .ALUResult(ALUResult), .ALUFlagC(ALUFlagC), .ALUFlagZ(ALUFlagZ),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bench ALU ----------------
    logic [N:0] alu_sum;
    always_comb begin
        alu_sum   = (N+1)'(ALUA) + (N+1)'(ALUB) + (N+1)'(ALUFlagIn);
        ALUResult = '0;
        ALUFlagC  = 1'b0;
        case (ALUControl)
            4'd0: ALUResult = ALUA & ALUB;
            4'd1: ALUResult = ALUA | ALUB;
            4'd2: begin
                ALUResult = alu_sum[N-1:0];
                ALUFlagC  = alu_sum[N];
            end
            4'd5: ALUResult = ALUFlagIn ? ~ALUB : ~ALUA;
            4'd7: ALUResult = ALUA ^ ALUB;
            default: ALUResult = '0;
        endcase
        ALUFlagZ = (ALUResult == '0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction model ----------------
    logic [W-1:0] exp_q[$];
    bit           m_busy = 1'b0;
    int           m_after = 0;
    int           m_need = 0;
    logic [63:0]  m_a = '0;
    logic [63:0]  m_b = '0;
    logic [3:0]   m_op = '0;
    logic         m_cin = 1'b0;
    logic         m_err = 1'b0;
    logic         m_c = 1'b0;
    logic         m_z = 1'b0;

    function automatic logic [63:0] word_of(input logic [63:0] v, input int k);
        return (v >> (k * N)) & ((64'd1 << N) - 64'd1);
    endfunction

    // Carry into word k is the carry out of the low k words added as plain integers.
    function automatic logic [63:0] carry_into(input int k);
        logic [63:0] lowm;
        lowm = (64'd1 << (k * N)) - 64'd1;
        return ((m_a & lowm) + (m_b & lowm) + 64'(m_cin)) >> (k * N);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 1'b0;
            exp_q.delete();
        end else if (m_busy) begin
            if (m_after >= m_need) begin
                if (rsp_ready) begin
                    m_busy = 1'b0;
                    void'(exp_q.pop_front());
                end
            end else begin
                m_after++;
            end
        end else if (req_valid) begin
            logic [63:0] r;
            m_a   = 64'(req_a);
            m_b   = 64'(req_b);
            m_op  = req_op;
            m_cin = req_cin;
            m_err = 1'b0;
            m_c   = 1'b0;
            r     = '0;
            case (req_op)
                4'd0: r = m_a & m_b;
                4'd1: r = m_a | m_b;
                4'd2: begin
                    r   = m_a + m_b + 64'(req_cin);
                    m_c = r[W];
                end
                4'd5: r = ~m_a;
                4'd7: r = m_a ^ m_b;
                default: m_err = 1'b1;
            endcase
            r      = r & ((64'd1 << W) - 64'd1);
            m_z    = !m_err && (r == 64'd0);
            m_need = m_err ? 0 : WORDS;
            m_after = 0;
            m_busy  = 1'b1;
            exp_q.push_back(W'(r));
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst) begin
            check("rst_alu_ports", 64'({ALUA, ALUB, ALUFlagIn, ALUControl}), 64'd0);
            check("rst_rsp", 64'({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err}), 64'd0);
        end else begin
            bit ev;
            ev = m_busy && (m_after >= m_need);
            check("req_ready", 64'(req_ready), 64'(!m_busy));
            check("rsp_valid", 64'(rsp_valid), 64'(ev));
            if (ev) begin
                if (exp_q.size() > 0)
                    check("rsp_result", 64'(rsp_result), 64'(exp_q[0]));
                else
                    check("exp_q_empty", 64'(exp_q.size()), 64'd1);
                check("rsp_carry", 64'(rsp_carry), 64'(m_c));
                check("rsp_zero", 64'(rsp_zero), 64'(m_z));
                check("rsp_err", 64'(rsp_err), 64'(m_err));
            end else if (m_busy && !m_err) begin
                check("alu_a", 64'(ALUA), word_of(m_a, m_after));
                check("alu_b", 64'(ALUB), word_of(m_b, m_after));
                check("alu_ctl", 64'(ALUControl), 64'(m_op));
                check("alu_fin", 64'(ALUFlagIn), (m_op == 4'd2) ? carry_into(m_after) : 64'd0);
            end
            if (!m_busy || m_err)
                check("alu_idle_zero", 64'({ALUA, ALUB, ALUFlagIn, ALUControl}), 64'd0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic release_rsp(input bit pre_valid, input logic [3:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] keep_result);
        @(negedge clk);
        rsp_ready = 1'b1;
        if (pre_valid) begin
            req_valid = 1'b1;
            req_op    = op;
            req_a     = a;
            req_b     = b;
            req_cin   = 1'b0;
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check("ready_after_release", 64'(req_ready), 64'd1);
        check("valid_after_release", 64'(rsp_valid), 64'd0);
        check("result_kept", 64'(rsp_result), 64'(keep_result));
    endtask

    task automatic run_req(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] er, input logic ec,
                           input logic ez, input logic ee, input bit chk_fin,
                           input logic [3:0] exp_fin, input int hold, input bit rel);
        int edges;
        logic [3:0] fin_seq;
        fin_seq = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = 16'hDEAD;
        req_b     = 16'hBEEF;
        edges     = 0;
        while (!rsp_valid && edges < 20) begin
            if (edges < WORDS) fin_seq[edges] = ALUFlagIn;
            @(posedge clk);
            #1;
            edges++;
        end
        check("latency", 64'(edges), ee ? 64'd0 : 64'(WORDS));
        check("lit_result", 64'(rsp_result), 64'(er));
        check("lit_carry", 64'(rsp_carry), 64'(ec));
        check("lit_zero", 64'(rsp_zero), 64'(ez));
        check("lit_err", 64'(rsp_err), 64'(ee));
        if (chk_fin) check("flagin_seq", 64'(fin_seq), 64'(exp_fin));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_ready", 64'(req_ready), 64'd0);
            check("hold_result", 64'({rsp_result, rsp_carry, rsp_zero, rsp_err}),
                  64'({er, ec, ez, ee}));
        end
        if (rel) release_rsp(1'b0, 4'd0, '0, '0, er);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b1;
        #21 rst = 1'b0;
        #1;
        check("reset_ready", 64'(req_ready), 64'd1);
        check("reset_valid", 64'(rsp_valid), 64'd0);
        check("reset_result", 64'(rsp_result), 64'd0);

        run_req(4'd2, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0110, 0, 1'b1);
        run_req(4'd2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1110, 0, 1'b1);
        run_req(4'd2, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 0, 1'b1);
        run_req(4'd7, 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 0, 1'b1);
        run_req(4'd5, 16'h0F0F, 16'h1234, 1'b1, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 0, 1'b1);
        run_req(4'd0, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b1);
        run_req(4'd1, 16'h1200, 16'h0034, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b1);
        run_req(4'd8, 16'h1111, 16'h2222, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 0, 1'b1);
        run_req(4'd3, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1, 1'b1);

        // Backpressure, then a request already waiting at the release edge.
        run_req(4'd2, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3, 1'b0);
        release_rsp(1'b1, 4'd5, 16'h0F0F, 16'h0000, 16'h2345);
        run_req(4'd5, 16'h0F0F, 16'h0000, 1'b0, 16'hF0F0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b1);

        // Reset while the third word is on the ALU.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'd2;
        req_a     = 16'h1234;
        req_b     = 16'h1111;
        req_cin   = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_alu_a", 64'(ALUA), 64'h2);
        rst = 1'b1;
        #1;
        check("mid_rst_alu", 64'({ALUA, ALUB, ALUFlagIn, ALUControl}), 64'd0);
        check("mid_rst_rsp", 64'({rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err}), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_no_valid", 64'(rsp_valid), 64'd0);
        run_req(4'd2, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 0, 1'b1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        n_bad++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
